// File: rtl/core_pkg.sv
// Shared core definitions: default datapath width, fetch step and the
// instruction buffer entry layout.
package core_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int INST_STEP = 4;

  // One instruction buffer slot: fetched word plus the address it came from.
  typedef struct packed {
    logic [XLEN_DEF-1:0] inst;
    logic [XLEN_DEF-1:0] pc;
  } buf_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Next pointers and count; flush wins over push and pop.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FULL_C) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful where count says so.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential requests to instruction memory,
// pairs in-order responses with their addresses and buffers them for the
// decode stage. Redirects flush the buffer and squash responses still in
// flight for the old path.
module fetch_stage
  import core_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]   MAXO_C  = CW'(MAX_OUTST);
  localparam logic [XLEN-1:0] STEP_C  = XLEN'(INST_STEP);

  logic [XLEN-1:0]   fpc_q, fpc_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     buf_cnt;
  logic [CW-1:0]     outst;
  logic [CW:0]       occ;
  logic [XLEN-1:0]   pc_head;
  logic [2*XLEN-1:0] buf_head;
  logic              req_core, req_acc;
  logic              rsp_acc, rsp_keep;
  logic              buf_pop, inst_vld;

  // Handshake qualification. Responses with nothing outstanding belong to
  // requests from before a reset and are ignored outright.
  always_comb begin
    occ      = {1'b0, buf_cnt} + {1'b0, outst};
    req_core = !redirect_i && (occ < DEPTH_C) && (outst < MAXO_C);
    req_acc  = req_core && imem_gnt_i;
    rsp_acc  = imem_rvalid_i && (outst != '0);
    rsp_keep = rsp_acc && (drop_q == '0) && !redirect_i;
    inst_vld = (buf_cnt != '0);
    buf_pop  = inst_vld && inst_ready_i && !redirect_i;
  end

  // Fetch PC and squash counter. On redirect every request still in flight
  // is stale; outstanding already includes any earlier pending drops, so the
  // new drop count is simply what remains after this cycle's response.
  always_comb begin
    fpc_d  = fpc_q;
    drop_d = drop_q;
    if (redirect_i) begin
      fpc_d  = {redirect_pc_i[XLEN-1:2], 2'b00};
      drop_d = outst - CW'(rsp_acc);
    end else begin
      if (req_acc) fpc_d = fpc_q + STEP_C;
      if (rsp_acc && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // Fetch PC and drop counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fpc_q  <= RESET_PC;
      drop_q <= '0;
    end else begin
      fpc_q  <= fpc_d;
      drop_q <= drop_d;
    end
  end

  // Addresses of issued requests; its occupancy is the outstanding count.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (1'b0),
    .push_i  (req_acc),
    .data_i  (fpc_q),
    .pop_i   (rsp_acc),
    .data_o  (pc_head),
    .count_o (outst)
  );

  // Fetched instructions waiting for decode, stored as {inst, pc}.
  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_inst_buf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (redirect_i),
    .push_i  (rsp_keep),
    .data_i  ({imem_rdata_i, pc_head}),
    .pop_i   (buf_pop),
    .data_o  (buf_head),
    .count_o (buf_cnt)
  );

  // Request is forced low while reset is held so nothing escapes during it.
  assign imem_req_o   = req_core && rst_n_i;
  assign imem_addr_o  = fpc_q;
  assign inst_valid_o = inst_vld;
  assign inst_o       = inst_vld ? buf_head[2*XLEN-1:XLEN] : '0;
  assign inst_pc_o    = inst_vld ? buf_head[XLEN-1:0]      : '0;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b1;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  fetch_stage #(
    .XLEN      (32),
    .RESET_PC  (RESET_PC),
    .DEPTH     (4),
    .MAX_OUTST (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else pass_cnt++;
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memfun(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: the program is a straight-line stream from the last
  // reset/redirect target; both deliveries and requests must follow it.
  logic [63:0] exp_q[$];
  logic [31:0] exp_next;
  logic [31:0] req_next;

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back({memfun(exp_next), exp_next});
      exp_next += 32'd4;
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    exp_next = {a[31:2], 2'b00};
    req_next = exp_next;
    refill();
  endtask

  // Memory model: in-order responses after a programmable latency.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];
  int cyc = 0;
  int lat = 0;
  int gnt_mode = 0;

  always @(posedge clk_i) begin
    #1;
    cyc++;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memfun(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    case (gnt_mode)
      0:       imem_gnt_i = 1'b1;
      1:       imem_gnt_i = 1'b0;
      default: imem_gnt_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor / scoreboard, sampling mid-cycle.
  logic        hold_prev = 1'b0;
  logic [31:0] addr_prev = '0;

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) check("addr_hold", imem_addr_o, addr_prev);
      hold_prev = imem_req_o && !imem_gnt_i;
      addr_prev = imem_addr_o;
      if (redirect_i) check("req_on_redirect", imem_req_o, 0);
      if (imem_req_o && imem_gnt_i) begin
        check("req_addr", imem_addr_o, req_next);
        req_next += 32'd4;
        pend_q.push_back('{addr: imem_addr_o, due: cyc + 1 + lat});
      end
      if (inst_valid_o && inst_ready_i && !redirect_i) begin
        refill();
        check("deliver", {inst_o, inst_pc_o}, exp_q[0]);
        void'(exp_q.pop_front());
        refill();
      end
    end
  end

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    @(negedge clk_i);
    while (!inst_valid_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(name, inst_valid_o, 1);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_i    = 1'b1;
    redirect_pc_i = tgt;
    cycle();
    redirect_i = 1'b0;
    restart(tgt);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rec;
    int n;
    restart(RESET_PC);

    // Reset state
    repeat (3) cycle();
    check("rst_req", imem_req_o, 0);
    check("rst_valid", inst_valid_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_pc", inst_pc_o, 0);
    check("rst_addr", imem_addr_o, RESET_PC);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("first_req", imem_req_o, 1);
    check("first_addr", imem_addr_o, RESET_PC);

    // Zero-wait streaming, one instruction per cycle
    wait_valid("first_valid", 10);
    check("seq_pc0", inst_pc_o, 32'h0);
    check("seq_inst0", inst_o, memfun(32'h0));
    @(negedge clk_i);
    check("seq_pc4", {inst_valid_o, inst_pc_o}, {1'b1, 32'h4});
    @(negedge clk_i);
    check("seq_pc8", {inst_valid_o, inst_pc_o}, {1'b1, 32'h8});
    check("seq_inst8", inst_o, memfun(32'h8));
    @(negedge clk_i);
    check("seq_pcC", {inst_valid_o, inst_pc_o}, {1'b1, 32'hC});

    // Downstream stall: buffer fills, requests stop, nothing lost
    cycle();
    inst_ready_i = 1'b0;
    repeat (10) cycle();
    @(negedge clk_i);
    check("stall_req", imem_req_o, 0);
    check("stall_valid", inst_valid_o, 1);
    check("stall_pc", inst_pc_o, 32'h10);
    cycle();
    inst_ready_i = 1'b1;
    repeat (6) cycle();

    // Redirect with two responses in flight
    lat = 4;
    n = 0;
    while (pend_q.size() < 2 && n < 30) begin
      cycle();
      n++;
    end
    check("two_outstanding", (pend_q.size() >= 2), 1);
    do_redirect(32'h100);
    @(negedge clk_i);
    check("valid_after_redir1", inst_valid_o, 0);
    lat = 0;
    wait_valid("redir1_valid", 30);
    check("redir1_pc", {inst_o, inst_pc_o}, {memfun(32'h100), 32'h100});
    repeat (8) cycle();

    // Unaligned target, redirect coinciding with response and pop
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h203;
    @(negedge clk_i);
    check("coincide_valid", inst_valid_o, 1);
    cycle();
    redirect_i = 1'b0;
    restart(32'h203);
    @(negedge clk_i);
    check("valid_after_redir2", inst_valid_o, 0);
    check("redir2_addr", {imem_req_o, imem_addr_o}, {1'b1, 32'h200});
    wait_valid("redir2_valid", 20);
    check("redir2_pc", inst_pc_o, 32'h200);
    repeat (4) cycle();

    // Grant held low: address must not move
    gnt_mode = 1;
    cycle();
    cycle();
    @(negedge clk_i);
    rec = imem_addr_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("gnt_low_addr", {imem_req_o, imem_addr_o}, {1'b1, rec});
    end
    cycle();
    gnt_mode = 0;

    // Address wrap
    do_redirect(32'hFFFF_FFF4);
    n = 0;
    @(negedge clk_i);
    while (!(imem_req_o && imem_gnt_i && imem_addr_o == 32'hFFFF_FFFC) && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    check("wrap_reach", imem_addr_o, 32'hFFFF_FFFC);
    n = 0;
    @(negedge clk_i);
    while (!(imem_req_o && imem_gnt_i) && n < 30) begin
      @(negedge clk_i);
      n++;
    end
    check("wrap_addr", {imem_req_o, imem_addr_o}, {1'b1, 32'h0});
    repeat (10) cycle();

    // Reset with requests in flight; late responses must be ignored
    lat = 6;
    n = 0;
    while (pend_q.size() < 2 && n < 30) begin
      cycle();
      n++;
    end
    gnt_mode = 1;
    cycle();
    rst_n_i = 1'b0;
    restart(RESET_PC);
    #1;
    check("midrst_req", imem_req_o, 0);
    check("midrst_valid", inst_valid_o, 0);
    check("midrst_inst", inst_o, 0);
    check("midrst_pc", inst_pc_o, 0);
    cycle();
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_req", {imem_req_o, imem_addr_o}, {1'b1, RESET_PC});
    n = 0;
    while (pend_q.size() > 0 && n < 30) begin
      @(negedge clk_i);
      check("no_stale", inst_valid_o, 0);
      n++;
    end
    cycle();
    lat = 0;
    gnt_mode = 0;
    wait_valid("post_rst_valid", 20);
    check("post_rst_pc", {inst_o, inst_pc_o}, {memfun(RESET_PC), RESET_PC});

    // Randomized traffic
    gnt_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      cycle();
      inst_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(0, 4);
      if ($urandom_range(0, 39) == 0) do_redirect($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst_n_i = 1'b0;
        pend_q.delete();
        restart(RESET_PC);
        cycle();
        rst_n_i = 1'b1;
      end
    end

    inst_ready_i = 1'b1;
    gnt_mode = 0;
    repeat (30) cycle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter XLEN, 32, width of PC, address and instruction.
REQ-002 SHALL provide parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL provide parameter DEPTH, 4, instruction buffer entries (power of two, 2..16).
REQ-004 SHALL provide parameter MAX_OUTST, 2, maximum in-flight memory requests (1..DEPTH).
REQ-005 SHALL have port clk_i  input  1  the single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports imem_req_o  output  1, imem_addr_o  output  XLEN, imem_gnt_i  input  1: request handshake, accepted when req and gnt are both high.
REQ-008 SHALL have ports imem_rvalid_i  input  1, imem_rdata_i  input  XLEN: in-order response, always accepted, no back-pressure.
REQ-009 SHALL have ports redirect_i  input  1, redirect_pc_i  input  XLEN: branch or jump redirect.
REQ-010 SHALL have ports inst_valid_o  output  1, inst_ready_i  input  1, inst_o  output  XLEN, inst_pc_o  output  XLEN: downstream handshake.

Function
REQ-011 SHALL keep fetch PC (fpc); imem_addr_o = fpc; fpc += 4 (mod 2^XLEN, wraps) on each accepted request.
REQ-012 SHALL assert imem_req_o only when not redirecting this cycle and (buffer count + outstanding) < DEPTH and outstanding < MAX_OUTST.
REQ-013 SHALL hold imem_addr_o stable while imem_req_o is high and gnt is low.
REQ-014 SHALL keep a PC FIFO of issued addresses so that each response is paired with its PC.
REQ-015 SHALL push {rdata, pc} into the DEPTH-entry buffer on each non-discarded rvalid; the buffer never overflows because of REQ-012.
REQ-016 SHALL drive inst_valid_o = buffer not empty; inst_o/inst_pc_o = head entry; pop on valid and ready.
REQ-017 SHALL support push and pop in the same cycle with a full buffer (count unchanged).
REQ-018 SHALL, on redirect_i: flush the buffer, set fpc = {redirect_pc_i[XLEN-1:2], 2'b00}, set drop count = outstanding minus any response arriving that same cycle, and deassert imem_req_o for that cycle.
REQ-019 SHALL discard responses while drop count > 0 and decrement it per response; it SHALL NOT push them.
REQ-020 SHALL let a new redirect during draining add to the remaining drop count (same accounting rule).
REQ-021 SHALL give redirect priority over pop and push in the same cycle; inst_valid_o is low the cycle after a redirect.
REQ-022 SHALL update outstanding as +1 on accepted request and -1 on any response, including discarded ones.
REQ-023 SHALL achieve minimum latency of 1 cycle from rvalid to inst_valid_o, and sustain 1 instruction/cycle with a zero-wait memory.

Reset
REQ-024 SHALL, with rst_n_i low, asynchronously set fpc=RESET_PC, buffer empty, outstanding=0, drop=0, imem_req_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0.
REQ-025 SHALL, on reset mid-operation, abandon all in-flight state; memory responses arriving after reset release SHALL NOT be accepted unless requested after release.
REQ-026 SHALL issue its first request on the first clock edge after rst_n_i rises.

Structure
REQ-027 SHALL place the XLEN default, the instruction-step constant 4 and the buffer entry struct {inst, pc} in shared package core_pkg.
REQ-028 SHALL instantiate one generic sub-module sync_fifo (parametrised width/depth, count output), used for both the instruction buffer and the PC FIFO.

Verification
REQ-029 SHALL cover: reset release, zero-wait memory, ready=1 -> inst_pc_o sequence 0x0,0x4,0x8 on consecutive cycles, inst_o equals memory contents.
REQ-030 SHALL cover: inst_ready_i=0 for 10 cycles -> buffer fills to DEPTH=4, imem_req_o drops, no entry is lost; on release, PCs continue 0x10.
REQ-031 SHALL cover: redirect to 0x100 with 2 responses outstanding -> both discarded, next inst_pc_o=0x100.
REQ-032 SHALL cover: redirect_pc_i=0x203 -> fetch address 0x200; redirect coinciding with rvalid and pop -> no stale instruction is delivered.
REQ-033 SHALL cover: gnt held low 5 cycles -> imem_addr_o stable; fpc=0xFFFF_FFFC -> next address wraps to 0x0.
REQ-034 SHALL cover: rst_n_i asserted with 2 requests in flight -> outputs zero immediately; after release, first inst_pc_o=RESET_PC.
